sound_comm: RTL and testbench
=============================

SOUND_COMM -- requirements
Module: sound_comm

Interface
REQ-001 SHALL have parameter CE_SND_INC, default 9775, meaning the 16-bit phase increment per clk_main cycle for the Z80/YM clock enable (~3.58 MHz at 24 MHz).
REQ-002 SHALL have parameter CE_VOICE_INC, default 1748, meaning the 16-bit phase increment per clk_main cycle for the NEC voice/theme clock enable (~640 kHz).
REQ-003 clk_main  input  1  system clock (24 MHz); the single clock of the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SNDDT  input  1  active-low 68k sound-code write strobe from the CPU address decoder.
REQ-006 SNDON  input  1  68k-controlled Z80 IRQ trigger level; a rising edge requests an interrupt.
REQ-007 cpu_din  input  8  68k data bus low byte (m68k_dout[7:0]).
REQ-008 nLATCH_RD  input  1  active-low Z80 read strobe of the sound-code latch.
REQ-009 nM1  input  1  Z80 M1, active low.
REQ-010 nIORQ  input  1  Z80 IORQ, active low.
REQ-011 sound_code  output  8  latched sound command presented to the Z80 data mux.
REQ-012 z80_nINT  output  1  Z80 maskable interrupt, active low.
REQ-013 latch_full  output  1  high while a written code has not yet been read by the Z80.
REQ-014 overrun  output  1  sticky: a code was overwritten before being read.
REQ-015 ce_snd  output  1  one-cycle clock enable, ~3.58 MHz average rate.
REQ-016 ce_voice  output  1  one-cycle clock enable, ~640 kHz average rate.

Function
REQ-017 All strobe inputs (SNDDT, SNDON, nLATCH_RD, nM1, nIORQ) SHALL be registered once in clk_main before edge detection; edges SHALL be detected against the previous registered value.
REQ-018 On a detected 1->0 edge of SNDDT, sound_code SHALL load cpu_din as sampled in the same cycle as the registered edge, visible on the following cycle (2-cycle latency from strobe fall to output).
REQ-019 The same SNDDT edge SHALL set latch_full; if latch_full was already 1, overrun SHALL be set and remain set until reset.
REQ-020 A detected 1->0 edge of nLATCH_RD SHALL clear latch_full; sound_code SHALL NOT change on a read.
REQ-021 Simultaneous SNDDT write edge and nLATCH_RD edge in the same cycle: write wins, latch_full stays 1, new data loaded, overrun not set by that event.
REQ-022 Holding SNDDT low for many cycles SHALL produce exactly one write; holding nLATCH_RD low SHALL produce exactly one clear.
REQ-023 Interrupt state machine: IDLE (z80_nINT=1) -> PEND (z80_nINT=0) on a registered 0->1 edge of SNDON; PEND -> IDLE on the first cycle where registered nM1 and nIORQ are both 0 (interrupt acknowledge).
REQ-024 A SNDON rising edge in the same cycle as an acknowledge SHALL leave the state in PEND.
REQ-025 Additional SNDON edges while PEND SHALL have no further effect (no queuing).
REQ-026 SNDON held high SHALL NOT re-trigger after acknowledge; only a new 0->1 edge re-enters PEND.
REQ-027 Each clock enable SHALL be the carry-out of a dedicated 16-bit accumulator adding its increment every clk_main cycle; the enable is high for exactly the cycle the carry occurs; accumulator wraps modulo 65536.
REQ-028 Over any 65536 consecutive cycles, ce_snd SHALL pulse exactly CE_SND_INC times and ce_voice exactly CE_VOICE_INC times; no two pulses of the same enable SHALL be adjacent while increment < 32768.

Reset
REQ-029 While reset is high: sound_code=0x00, latch_full=0, overrun=0, z80_nINT=1 (IDLE), ce_snd=0, ce_voice=0, both accumulators=0.
REQ-030 Reset SHALL preset registered active-low strobes to 1 and registered SNDON to 0, so no edge is detected on the first cycle after reset release regardless of input levels.
REQ-031 Reset asserted mid-operation (latch full, IRQ pending) SHALL return all state to reset values on the next clock edge.

Verification
REQ-032 cpu_din=0x5A, SNDDT low 4 cycles -> sound_code=0x5A two cycles after fall, latch_full=1, single write.
REQ-033 Write 0x11, write 0x22 without read -> sound_code=0x22, overrun=1; nLATCH_RD pulse -> latch_full=0, overrun stays 1.
REQ-034 SNDON 0->1 -> z80_nINT=0 two cycles later; nM1=nIORQ=0 one cycle -> z80_nINT=1; SNDON held high -> z80_nINT stays 1.
REQ-035 SNDON edge coincident with acknowledge -> z80_nINT remains 0.
REQ-036 Free-run 65536 cycles after reset -> exactly 9775 ce_snd and 1748 ce_voice pulses, each one cycle wide.
REQ-037 Inputs SNDDT=0, SNDON=1 held through reset release -> no write, no IRQ, latch_full=0, z80_nINT=1.

Source files
------------

// File: rtl/sound_comm.sv
// 68k -> Z80 sound-command mailbox: latched sound code with full/overrun flags,
// an edge-triggered Z80 interrupt request, and two fractional clock enables.
module sound_comm #(
    parameter logic [15:0] CE_SND_INC   = 16'd9775,
    parameter logic [15:0] CE_VOICE_INC = 16'd1748
) (
    input  logic       clk_main,
    input  logic       reset,
    input  logic       SNDDT,
    input  logic       SNDON,
    input  logic [7:0] cpu_din,
    input  logic       nLATCH_RD,
    input  logic       nM1,
    input  logic       nIORQ,
    output logic [7:0] sound_code,
    output logic       z80_nINT,
    output logic       latch_full,
    output logic       overrun,
    output logic       ce_snd,
    output logic       ce_voice,
    output logic       irq_state
);

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_PEND = 1'b1
    } irq_state_t;

    irq_state_t  r_irq_state;
    logic        r_snddt, r_snddt_q;
    logic        r_sndon, r_sndon_q;
    logic        r_nlatch_rd, r_nlatch_rd_q;
    logic        r_nm1, r_niorq;
    logic [1:0]  r_arm;
    logic [7:0]  r_sound_code;
    logic        r_latch_full, r_overrun, r_nint;
    logic [15:0] r_acc_snd, r_acc_voice;
    logic        r_ce_snd, r_ce_voice;

    logic        w_wr, w_rd, w_rise, w_ack;
    logic [16:0] w_sum_snd, w_sum_voice;

    // Strobe synchronisers. r_arm masks the first compare after reset release,
    // where the preset history would otherwise fake an edge from held inputs.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            r_snddt       <= 1'b1;
            r_snddt_q     <= 1'b1;
            r_sndon       <= 1'b0;
            r_sndon_q     <= 1'b0;
            r_nlatch_rd   <= 1'b1;
            r_nlatch_rd_q <= 1'b1;
            r_nm1         <= 1'b1;
            r_niorq       <= 1'b1;
            r_arm         <= 2'b00;
        end else begin
            r_snddt       <= SNDDT;
            r_snddt_q     <= r_snddt;
            r_sndon       <= SNDON;
            r_sndon_q     <= r_sndon;
            r_nlatch_rd   <= nLATCH_RD;
            r_nlatch_rd_q <= r_nlatch_rd;
            r_nm1         <= nM1;
            r_niorq       <= nIORQ;
            r_arm         <= {r_arm[0], 1'b1};
        end
    end

    assign w_wr   = r_arm[1] & r_snddt_q & ~r_snddt;
    assign w_rd   = r_arm[1] & r_nlatch_rd_q & ~r_nlatch_rd;
    assign w_rise = r_arm[1] & ~r_sndon_q & r_sndon;
    assign w_ack  = ~r_nm1 & ~r_niorq;

    // A write coinciding with a read counts as a fresh, unread code.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            r_sound_code <= 8'h00;
            r_latch_full <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_wr) begin
            r_sound_code <= cpu_din;
            r_latch_full <= 1'b1;
            if (r_latch_full && !w_rd) begin
                r_overrun <= 1'b1;
            end
        end else if (w_rd) begin
            r_latch_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_main) begin
        if (reset) begin
            r_irq_state <= IRQ_IDLE;
            r_nint      <= 1'b1;
        end else begin
            case (r_irq_state)
                IRQ_IDLE: begin
                    if (w_rise) begin
                        r_irq_state <= IRQ_PEND;
                        r_nint      <= 1'b0;
                    end
                end
                IRQ_PEND: begin
                    if (w_ack && !w_rise) begin
                        r_irq_state <= IRQ_IDLE;
                        r_nint      <= 1'b1;
                    end
                end
                default: begin
                    r_irq_state <= IRQ_IDLE;
                    r_nint      <= 1'b1;
                end
            endcase
        end
    end

    // Fractional dividers: the accumulator carry is the enable pulse.
    assign w_sum_snd   = {1'b0, r_acc_snd} + {1'b0, CE_SND_INC};
    assign w_sum_voice = {1'b0, r_acc_voice} + {1'b0, CE_VOICE_INC};

    always_ff @(posedge clk_main) begin
        if (reset) begin
            r_acc_snd   <= 16'h0000;
            r_acc_voice <= 16'h0000;
            r_ce_snd    <= 1'b0;
            r_ce_voice  <= 1'b0;
        end else begin
            r_acc_snd   <= w_sum_snd[15:0];
            r_acc_voice <= w_sum_voice[15:0];
            r_ce_snd    <= w_sum_snd[16];
            r_ce_voice  <= w_sum_voice[16];
        end
    end

    assign sound_code = r_sound_code;
    assign latch_full = r_latch_full;
    assign overrun    = r_overrun;
    assign z80_nINT   = r_nint;
    assign ce_snd     = r_ce_snd;
    assign ce_voice   = r_ce_voice;
    assign irq_state  = r_irq_state;

endmodule

// File: tb/tb_sound_comm.sv
// Bench for sound_comm: mailbox/IRQ vector table, timing corner cases, and
// a full-period count of both clock enables.
module tb_sound_comm;

    localparam int OP_WR   = 0;
    localparam int OP_RD   = 1;
    localparam int OP_SON  = 2;
    localparam int OP_ACK  = 3;
    localparam int OP_IDLE = 4;
    localparam int NVEC    = 11;

    // exp packs {sound_code, latch_full, overrun, z80_nINT}
    typedef struct {
        string      name;
        int         op;
        logic [7:0] data;
        int         len;
        logic [10:0] exp;
    } vec_t;

    logic       clk_main = 1'b0;
    logic       reset;
    logic       SNDDT, SNDON, nLATCH_RD, nM1, nIORQ;
    logic [7:0] cpu_din;
    logic [7:0] sound_code;
    logic       z80_nINT, latch_full, overrun, ce_snd, ce_voice, irq_state;

    int checks = 0;
    int failures = 0;
    logic [10:0] exp_q[$];
    vec_t vecs[NVEC];

    sound_comm dut (
        .clk_main  (clk_main),
        .reset     (reset),
        .SNDDT     (SNDDT),
        .SNDON     (SNDON),
        .cpu_din   (cpu_din),
        .nLATCH_RD (nLATCH_RD),
        .nM1       (nM1),
        .nIORQ     (nIORQ),
        .sound_code(sound_code),
        .z80_nINT  (z80_nINT),
        .latch_full(latch_full),
        .overrun   (overrun),
        .ce_snd    (ce_snd),
        .ce_voice  (ce_voice),
        .irq_state (irq_state)
    );

    always #5 clk_main = ~clk_main;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_main);
            @(negedge clk_main);
        end
    endtask

    function automatic logic [10:0] pack_state();
        return {sound_code, latch_full, overrun, z80_nINT};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    task automatic drive_op(input int op, input logic [7:0] data, input int len);
        case (op)
            OP_WR: begin
                cpu_din = data;
                SNDDT = 1'b0;
                cyc(len);
                SNDDT = 1'b1;
            end
            OP_RD: begin
                nLATCH_RD = 1'b0;
                cyc(len);
                nLATCH_RD = 1'b1;
            end
            OP_SON: begin
                SNDON = data[0];
                cyc(len);
            end
            OP_ACK: begin
                nM1 = 1'b0;
                nIORQ = 1'b0;
                cyc(len);
                nM1 = 1'b1;
                nIORQ = 1'b1;
            end
            default: cyc(len);
        endcase
        cyc(4);
    endtask

    initial begin
        int cnt_snd, cnt_voice, adj_snd, adj_voice;
        logic prev_snd, prev_voice;
        logic [10:0] want;

        vecs[0]  = '{"wr_5a_hold4",   OP_WR,   8'h5A, 4, {8'h5A, 1'b1, 1'b0, 1'b1}};
        vecs[1]  = '{"rd_hold3",      OP_RD,   8'h00, 3, {8'h5A, 1'b0, 1'b0, 1'b1}};
        vecs[2]  = '{"wr_11",         OP_WR,   8'h11, 1, {8'h11, 1'b1, 1'b0, 1'b1}};
        vecs[3]  = '{"wr_22_overrun", OP_WR,   8'h22, 2, {8'h22, 1'b1, 1'b1, 1'b1}};
        vecs[4]  = '{"rd_keep_ovr",   OP_RD,   8'h00, 1, {8'h22, 1'b0, 1'b1, 1'b1}};
        vecs[5]  = '{"sndon_rise",    OP_SON,  8'h01, 1, {8'h22, 1'b0, 1'b1, 1'b0}};
        vecs[6]  = '{"sndon_fall",    OP_SON,  8'h00, 1, {8'h22, 1'b0, 1'b1, 1'b0}};
        vecs[7]  = '{"sndon_requeue", OP_SON,  8'h01, 1, {8'h22, 1'b0, 1'b1, 1'b0}};
        vecs[8]  = '{"ack",           OP_ACK,  8'h00, 1, {8'h22, 1'b0, 1'b1, 1'b1}};
        vecs[9]  = '{"sndon_held",    OP_IDLE, 8'h00, 5, {8'h22, 1'b0, 1'b1, 1'b1}};
        vecs[10] = '{"wr_c3_hold6",   OP_WR,   8'hC3, 6, {8'hC3, 1'b1, 1'b1, 1'b1}};

        reset = 1'b1;
        SNDDT = 1'b1;
        SNDON = 1'b0;
        nLATCH_RD = 1'b1;
        nM1 = 1'b1;
        nIORQ = 1'b1;
        cpu_din = 8'h00;
        @(negedge clk_main);
        cyc(3);
        check("reset_state", 32'(pack_state()), 32'({8'h00, 1'b0, 1'b0, 1'b1}));
        check("reset_ce", 32'({ce_snd, ce_voice}), 32'd0);
        reset = 1'b0;
        cyc(3);

        for (int i = 0; i < NVEC; i++) begin
            exp_q.push_back(vecs[i].exp);
            drive_op(vecs[i].op, vecs[i].data, vecs[i].len);
            want = exp_q.pop_front();
            check(vecs[i].name, 32'(pack_state()), 32'(want));
        end

        // Write latency: new code appears on the second edge after the fall.
        cpu_din = 8'h77;
        SNDDT = 1'b0;
        cyc(1);
        check("wr_lat_edge1", 32'(sound_code), 32'h0C3);
        cyc(1);
        check("wr_lat_edge2", 32'(sound_code), 32'h077);
        SNDDT = 1'b1;
        cyc(4);

        // IRQ latency: z80_nINT drops on the second edge after SNDON rises.
        SNDON = 1'b0;
        cyc(3);
        SNDON = 1'b1;
        cyc(1);
        check("irq_lat_edge1", 32'(z80_nINT), 32'd1);
        cyc(1);
        check("irq_lat_edge2", 32'(z80_nINT), 32'd0);
        cyc(3);

        // New rising edge in the same cycle as an acknowledge keeps it pending.
        SNDON = 1'b0;
        nM1 = 1'b1;
        cyc(3);
        SNDON = 1'b1;
        nM1 = 1'b0;
        nIORQ = 1'b0;
        cyc(1);
        nM1 = 1'b1;
        nIORQ = 1'b1;
        cyc(3);
        check("irq_coincident_ack", 32'(z80_nINT), 32'd0);

        // Reset mid-operation (latch full, overrun, IRQ pending).
        reset = 1'b1;
        cyc(1);
        check("midop_reset_state", 32'(pack_state()), 32'({8'h00, 1'b0, 1'b0, 1'b1}));
        check("midop_reset_ce", 32'({ce_snd, ce_voice}), 32'd0);
        reset = 1'b0;
        SNDON = 1'b0;
        cyc(4);

        // Simultaneous write and read: write wins, no overrun.
        drive_op(OP_WR, 8'h99, 1);
        check("pre_simul", 32'(pack_state()), 32'({8'h99, 1'b1, 1'b0, 1'b1}));
        cpu_din = 8'hAB;
        SNDDT = 1'b0;
        nLATCH_RD = 1'b0;
        cyc(1);
        SNDDT = 1'b1;
        nLATCH_RD = 1'b1;
        cyc(4);
        check("simul_wr_rd", 32'(pack_state()), 32'({8'hAB, 1'b1, 1'b0, 1'b1}));

        // Active levels held through reset release must not trigger anything.
        reset = 1'b1;
        SNDDT = 1'b0;
        SNDON = 1'b1;
        cpu_din = 8'hEE;
        cyc(2);
        reset = 1'b0;
        cyc(8);
        check("held_through_reset", 32'(pack_state()), 32'({8'h00, 1'b0, 1'b0, 1'b1}));
        SNDDT = 1'b1;
        SNDON = 1'b0;
        cyc(4);
        check("held_then_released", 32'(pack_state()), 32'({8'h00, 1'b0, 1'b0, 1'b1}));

        // Free run one full accumulator period.
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cnt_snd = 0;
        cnt_voice = 0;
        adj_snd = 0;
        adj_voice = 0;
        prev_snd = 1'b0;
        prev_voice = 1'b0;
        for (int c = 0; c < 65536; c++) begin
            cyc(1);
            if (ce_snd) cnt_snd++;
            if (ce_voice) cnt_voice++;
            if (ce_snd && prev_snd) adj_snd++;
            if (ce_voice && prev_voice) adj_voice++;
            prev_snd = ce_snd;
            prev_voice = ce_voice;
        end
        check("ce_snd_count", 32'(cnt_snd), 32'd9775);
        check("ce_voice_count", 32'(cnt_voice), 32'd1748);
        check("ce_snd_adjacent", 32'(adj_snd), 32'd0);
        check("ce_voice_adjacent", 32'(adj_voice), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
